// File: rtl/ltsm_seq.sv
// ltsm_seq -- UCIe logical PHY link-training sequencer.
//
// Walks RESET -> SBINIT -> MBINIT -> MBTRAIN -> LINKINIT -> ACTIVE. On entry to
// each phase it pulses that phase's start for one cycle, then waits for the
// phase's done/error handshake. Each phase has a timeout. Errors go to
// TRAINERROR, which retries automatically up to MAX_RETRY times and then
// latches the error. ACTIVE can be sent back to MBTRAIN by a retrain request.
// A lane mask from MBINIT narrows the mainband width.
//
// Ports:
//   clk_100MHz, reset   : clock; asynchronous active-high reset
//   enable_i            : link enable, low forces RESET
//   start_LT_i          : level request to start (or restart) training
//   retrain_req_i       : retrain request, honoured in ACTIVE only
//   phase_done_i/err_i  : per-phase handshakes (0 SBINIT .. 3 LINKINIT)
//   lane_mask_i         : good-lane map, sampled with MBINIT done
//   phase_start_o       : one-cycle start pulse per phase
//   state_o             : current state (0 RESET .. 6 TRAINERROR)
//   link_up_o           : high in ACTIVE
//   train_error_o       : error latched after retries ran out
//   err_cause_o         : 0 none, 1 phase error, 2 timeout, 3 lane mask too narrow
//   retry_cnt_o         : retries used so far
//   sb_pin_sel_o        : sideband pin mux select
//   mb_pin_sel_o        : mainband pin mux select
//   mb_lane_en_o        : mainband lane enables
module ltsm_seq #(
    parameter int N_LANES      = 16,
    parameter int TIMEOUT_CYC  = 800000,
    parameter int ERR_HOLD_CYC = 1000,
    parameter int MAX_RETRY    = 3,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               enable_i,
    input  logic               start_LT_i,
    input  logic               retrain_req_i,
    input  logic [3:0]         phase_done_i,
    input  logic [3:0]         phase_err_i,
    input  logic [N_LANES-1:0] lane_mask_i,
    output logic [3:0]         phase_start_o,
    output logic [2:0]         state_o,
    output logic               link_up_o,
    output logic               train_error_o,
    output logic [1:0]         err_cause_o,
    output logic [RW-1:0]      retry_cnt_o,
    output logic [1:0]         sb_pin_sel_o,
    output logic [1:0]         mb_pin_sel_o,
    output logic [N_LANES-1:0] mb_lane_en_o
);

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_SBINIT     = 3'd1,
        ST_MBINIT     = 3'd2,
        ST_MBTRAIN    = 3'd3,
        ST_LINKINIT   = 3'd4,
        ST_ACTIVE     = 3'd5,
        ST_TRAINERROR = 3'd6
    } state_t;

    localparam int TMAX = (TIMEOUT_CYC > ERR_HOLD_CYC) ? TIMEOUT_CYC : ERR_HOLD_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(N_LANES + 1);

    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(ERR_HOLD_CYC - 1);
    localparam logic [TW-1:0] TIMER_SAT = TW'(TMAX);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [PW-1:0] MIN_LANES = PW'(N_LANES / 2);

    state_t             st_q, st_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N_LANES-1:0] mask_q, mask_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [1:0]         cause_q, cause_d;
    logic               terr_q, terr_d;
    logic [3:0]         start_q, start_d;

    logic [PW-1:0]      pop;
    logic               ph_done, ph_err;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            st_q    <= ST_RESET;
            timer_q <= '0;
            mask_q  <= '1;
            retry_q <= '0;
            cause_q <= '0;
            terr_q  <= 1'b0;
            start_q <= '0;
        end else begin
            st_q    <= st_d;
            timer_q <= timer_d;
            mask_q  <= mask_d;
            retry_q <= retry_d;
            cause_q <= cause_d;
            terr_q  <= terr_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            pop = pop + PW'(lane_mask_i[i]);
        end
    end

    // Only the handshake of the phase currently running is looked at.
    always_comb begin
        ph_done = 1'b0;
        ph_err  = 1'b0;
        case (st_q)
            ST_SBINIT:   begin ph_done = phase_done_i[0]; ph_err = phase_err_i[0]; end
            ST_MBINIT:   begin ph_done = phase_done_i[1]; ph_err = phase_err_i[1]; end
            ST_MBTRAIN:  begin ph_done = phase_done_i[2]; ph_err = phase_err_i[2]; end
            ST_LINKINIT: begin ph_done = phase_done_i[3]; ph_err = phase_err_i[3]; end
            default: ;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        mask_d  = mask_q;
        retry_d = retry_q;
        cause_d = cause_q;
        terr_d  = terr_q;
        start_d = '0;

        if (!enable_i) begin
            st_d    = ST_RESET;
            retry_d = '0;
            cause_d = '0;
            terr_d  = 1'b0;
        end else begin
            case (st_q)
                ST_RESET: begin
                    if (start_LT_i) st_d = ST_SBINIT;
                end
                ST_SBINIT, ST_MBINIT, ST_MBTRAIN, ST_LINKINIT: begin
                    // error beats done beats timeout
                    if (ph_err) begin
                        st_d    = ST_TRAINERROR;
                        cause_d = 2'd1;
                    end else if (ph_done) begin
                        case (st_q)
                            ST_SBINIT: st_d = ST_MBINIT;
                            ST_MBINIT: begin
                                mask_d = lane_mask_i;
                                if (pop < MIN_LANES) begin
                                    st_d    = ST_TRAINERROR;
                                    cause_d = 2'd3;
                                end else begin
                                    st_d = ST_MBTRAIN;
                                end
                            end
                            ST_MBTRAIN: st_d = ST_LINKINIT;
                            default: begin
                                st_d    = ST_ACTIVE;
                                retry_d = '0;
                            end
                        endcase
                    end else if (timer_q == TO_LAST) begin
                        st_d    = ST_TRAINERROR;
                        cause_d = 2'd2;
                    end
                end
                ST_ACTIVE: begin
                    if (retrain_req_i) st_d = ST_MBTRAIN;
                end
                ST_TRAINERROR: begin
                    if (terr_q) begin
                        if (start_LT_i) begin
                            st_d    = ST_SBINIT;
                            terr_d  = 1'b0;
                            retry_d = '0;
                            cause_d = '0;
                        end
                    end else if (timer_q == HOLD_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            st_d    = ST_SBINIT;
                            retry_d = retry_q + RW'(1);
                        end else begin
                            terr_d = 1'b1;
                        end
                    end
                end
                default: st_d = ST_RESET;
            endcase
        end

        // No state re-enters itself, so any change into a phase is an entry.
        if (st_d != st_q) begin
            case (st_d)
                ST_SBINIT:   start_d = 4'b0001;
                ST_MBINIT:   start_d = 4'b0010;
                ST_MBTRAIN:  start_d = 4'b0100;
                ST_LINKINIT: start_d = 4'b1000;
                default: ;
            endcase
        end

        if (st_d != st_q)          timer_d = '0;
        else if (timer_q == TIMER_SAT) timer_d = timer_q;
        else                       timer_d = timer_q + TW'(1);
    end

    always_comb begin
        sb_pin_sel_o = 2'd3;
        mb_pin_sel_o = 2'd0;
        mb_lane_en_o = '0;
        case (st_q)
            ST_RESET:      sb_pin_sel_o = 2'd1;
            ST_SBINIT:     sb_pin_sel_o = 2'd2;
            ST_MBINIT:     begin mb_pin_sel_o = 2'd2; mb_lane_en_o = '1;     end
            ST_MBTRAIN:    begin mb_pin_sel_o = 2'd2; mb_lane_en_o = mask_q; end
            ST_LINKINIT,
            ST_ACTIVE:     begin mb_pin_sel_o = 2'd3; mb_lane_en_o = mask_q; end
            ST_TRAINERROR: mb_pin_sel_o = 2'd1;
            default: ;
        endcase
    end

    assign state_o       = st_q;
    assign phase_start_o = start_q;
    assign link_up_o     = (st_q == ST_ACTIVE);
    assign train_error_o = terr_q;
    assign err_cause_o   = cause_q;
    assign retry_cnt_o   = retry_q;

endmodule

// File: doc/ltsm_seq.md
# ltsm_seq

Parametrised link-training sequencer for the UCIe logical PHY, the successor of the single-lane-group LTSM top. It walks the link through RESET → SBINIT → MBINIT → MBTRAIN → LINKINIT → ACTIVE, starting each phase sub-block and waiting for its done/error handshake. It adds per-phase timeouts, bounded automatic retry, retrain from ACTIVE, and a degraded-width lane mask. Its outputs drive the SB/MB pin-mux selects and the mainband lane enables.

## Interface
Parameters:
- N_LANES, 16, mainband data lanes; must be even and ≥2.
- TIMEOUT_CYC, 800000, per-phase timeout in clk_100MHz cycles (8 ms); ≥2.
- ERR_HOLD_CYC, 1000, minimum TRAINERROR dwell in cycles; ≥1.
- MAX_RETRY, 3, automatic retries before latching the error; ≥0.

Ports:
- clk_100MHz in 1: sequencer clock.
- reset in 1: asynchronous, active-high.
- enable_i in 1: link enable; low forces RESET.
- start_LT_i in 1: level request to start training.
- retrain_req_i in 1: retrain request, honoured in ACTIVE only.
- phase_done_i in 4: done per phase; bit0 SBINIT, bit1 MBINIT, bit2 MBTRAIN, bit3 LINKINIT.
- phase_err_i in 4: error per phase, same bit order.
- lane_mask_i in N_LANES: good-lane map from MBINIT, sampled with phase_done_i[1].
- phase_start_o out 4: one-cycle start pulse per phase.
- state_o out 3: RESET=0, SBINIT=1, MBINIT=2, MBTRAIN=3, LINKINIT=4, ACTIVE=5, TRAINERROR=6.
- link_up_o out 1: high in ACTIVE.
- train_error_o out 1: high while the error is latched (retries exhausted).
- err_cause_o out 2: 0 none, 1 phase error, 2 timeout, 3 lane mask too narrow.
- retry_cnt_o out $clog2(MAX_RETRY+1): retries used so far.
- sb_pin_sel_o out 2: 0 Z, 1 drive 0, 2 SBINIT, 3 COMS.
- mb_pin_sel_o out 2: 0 Z, 1 drive 0, 2 MBINIT/TRAIN, 3 COMS.
- mb_lane_en_o out N_LANES: mainband lane enables.

## Operation
- State register `st` is clocked by clk_100MHz; all outputs are registered or decoded only from registered state.
- enable_i=0 in any state → RESET on the next edge. This has priority over every other transition, clears err_cause_o and retry_cnt_o, and keeps the latched lane mask.
- RESET: if enable_i && start_LT_i → SBINIT.
- Phase state k (SBINIT..LINKINIT), resolved with priority error > done > timeout:
  - phase_err_i[k] → TRAINERROR, cause 1.
  - phase_done_i[k] → next state.
  - timer==TIMEOUT_CYC-1 → TRAINERROR, cause 2.
- Done/error bits of inactive phases are ignored.
- MBINIT done: lane_mask_i is latched into `mask`. If popcount(lane_mask_i) < N_LANES/2 → TRAINERROR, cause 3, instead of MBTRAIN.
- ACTIVE:
  - Entry clears retry_cnt_o.
  - retrain_req_i → MBTRAIN with a new phase_start_o[2] pulse. Retrain does not touch the retry count.
- TRAINERROR:
  - Dwell is at least ERR_HOLD_CYC cycles.
  - After the dwell, if retry_cnt_o < MAX_RETRY: retry_cnt_o++ and go to SBINIT.
  - Otherwise set train_error_o=1 and stay until start_LT_i. Then clear train_error_o, retry_cnt_o and err_cause_o, and go to SBINIT.
  - With MAX_RETRY=0, the first error latches immediately after the dwell.
- err_cause_o is written on entry to TRAINERROR and held until cleared (latched-error restart, or enable_i=0). A successful retry does not clear it.
- Timer, width $clog2(max(TIMEOUT_CYC, ERR_HOLD_CYC)+1): cleared on every state change, increments otherwise, and saturates.
- Pin selects per state:
  - RESET: sb=1, mb=0.
  - SBINIT: sb=2, mb=0.
  - MBINIT/MBTRAIN: sb=3, mb=2.
  - LINKINIT/ACTIVE: sb=3, mb=3.
  - TRAINERROR: sb=3, mb=1.
- mb_lane_en_o per state:
  - RESET/SBINIT/TRAINERROR: all 0.
  - MBINIT: all 1.
  - MBTRAIN/LINKINIT/ACTIVE: `mask`.
- Reset values:
  - st=RESET; phase_start_o=0; link_up_o=0; train_error_o=0; err_cause_o=0; retry_cnt_o=0.
  - sb_pin_sel_o=1; mb_pin_sel_o=0; mb_lane_en_o=0; mask=all 1; timer=0.

## Timing
- Every transition takes one edge after the qualifying input is sampled high.
- phase_start_o[k] is high exactly in the first cycle that state_o shows phase k, on every entry (including retry and retrain entries).
- A done or error input sampled in that same first cycle is honoured, so the minimum phase dwell is 1 cycle.
- Timeout: with no done/err, a phase occupies exactly TIMEOUT_CYC cycles. A done on the last of those cycles wins over the timeout.
- Fastest training, RESET → ACTIVE: 5 edges after start_LT_i when every done is returned in the first cycle.
- TRAINERROR occupies ERR_HOLD_CYC cycles before a retry; the retry SBINIT follows on the next edge.
- Reset asserted mid-training: all outputs return to their reset values asynchronously, with no start pulses.

## Test plan
Bench parameters: N_LANES=16, TIMEOUT_CYC=16, ERR_HOLD_CYC=4, MAX_RETRY=2.
- Happy path: enable_i=1, start_LT_i=1, each done pulsed 2 cycles after its start → state_o 1,2,3,4,5; four single-cycle start pulses; link_up_o=1; sb/mb=3/3; mb_lane_en_o=0xFFFF with lane_mask_i=0xFFFF.
- Degraded width: lane_mask_i=0x00FF → mb_lane_en_o=0x00FF in MBTRAIN; lane_mask_i=0x007F → TRAINERROR, err_cause_o=3, mb_pin_sel_o=1, mb_lane_en_o=0.
- Timeout: withhold MBTRAIN done → TRAINERROR exactly 16 cycles after MBTRAIN entry, cause 2. Done on cycle 16 instead → LINKINIT.
- Retry exhaustion: phase_err_i[0] on every SBINIT → retry_cnt_o 1 then 2; third error → train_error_o=1 and state held at 6; start_LT_i → counters cleared, SBINIT.
- Simultaneous events: phase_done_i[1] and phase_err_i[1] in the same cycle → TRAINERROR, cause 1. retrain_req_i in ACTIVE → MBTRAIN with phase_start_o=4'b0100, retry_cnt_o unchanged.
- Abort: enable_i=0 during LINKINIT → RESET next edge, link_up_o=0, sb=1, mb=0. Async reset during MBINIT → reset values immediately.
